// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, taken-branch squash,
// memory-busy freeze, EX operand forwarding selects and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_rf_en,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_en,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_en,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, STALL_LU} state_t;

  localparam logic [3:0]       LU_INIT = 4'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       stall_active;

  assign lu_hit = ex_load && ex_rf_en && (ex_rd != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  // In STALL_LU the hazard is not re-checked; the stall simply runs out its count.
  assign stall_active = (state_q == STALL_LU) || ((state_q == RUN) && lu_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mem_busy) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else if (ex_branch_taken) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else if (state_q == STALL_LU) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = RUN;
      end
    end else if (lu_hit && (LU_STALL > 1)) begin
      state_d = STALL_LU;
      cnt_d   = LU_INIT;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_active) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_rf_en && (mem_rd != 5'd0) && (mem_rd == src)) return 2'b10;
    if (wb_rf_en && (wb_rd != 5'd0) && (wb_rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a = reset ? 2'b00 : fwd_sel(ex_rs);
  assign fwd_b = reset ? 2'b00 : fwd_sel(ex_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_en && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (!mem_busy && ex_branch_taken && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl; two instances (LU_STALL=3 and 1)
// share inputs and are compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       reset;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_load, ex_rf_en, br;
    logic [4:0] mem_rd;
    logic       mem_rf_en;
    logic [4:0] wb_rd;
    logic       wb_rf_en, mem_busy;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic       id_use_rs = 0, id_use_rt = 0, ex_load = 0, ex_rf_en = 0, ex_branch_taken = 0;
  logic       mem_rf_en = 0, wb_rf_en = 0, mem_busy = 0;

  wire [9:0] ctl_a, ctl_b;
  wire [5:0] sc_a, fc_a;
  wire [3:0] sc_b, fc_b;

  pipeline_hazard_ctrl #(.LU_STALL(3), .CNT_W(6)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_rf_en(ex_rf_en), .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd),
    .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .mem_busy(mem_busy),
    .pc_en(ctl_a[9]), .ifid_en(ctl_a[8]), .ifid_flush(ctl_a[7]), .idex_en(ctl_a[6]),
    .idex_bubble(ctl_a[5]), .exmem_en(ctl_a[4]), .fwd_a(ctl_a[3:2]), .fwd_b(ctl_a[1:0]),
    .stall_count(sc_a), .flush_count(fc_a));

  pipeline_hazard_ctrl #(.LU_STALL(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_load(ex_load),
    .ex_rf_en(ex_rf_en), .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd),
    .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .mem_busy(mem_busy),
    .pc_en(ctl_b[9]), .ifid_en(ctl_b[8]), .ifid_flush(ctl_b[7]), .idex_en(ctl_b[6]),
    .idex_bubble(ctl_b[5]), .exmem_en(ctl_b[4]), .fwd_a(ctl_b[3:2]), .fwd_b(ctl_b[1:0]),
    .stall_count(sc_b), .flush_count(fc_b));

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model state per instance: stall cycles still owed after the current one, and counters.
  int lu_len[2] = '{3, 1};
  int cnt_w[2]  = '{6, 4};
  int owed[2]   = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  function automatic int fwdModel(input stim_t s, input logic [4:0] src);
    if (src == 0) return 0;
    if (s.mem_rf_en && s.mem_rd == src) return 2;
    if (s.wb_rf_en && s.wb_rd == src) return 1;
    return 0;
  endfunction

  function automatic bit luModel(input stim_t s);
    if (!(s.ex_load && s.ex_rf_en) || s.ex_rd == 0) return 0;
    return (s.id_use_rs && s.id_rs == s.ex_rd) || (s.id_use_rt && s.id_rt == s.ex_rd);
  endfunction

  function automatic int satInc(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    reset = s.reset; id_rs = s.id_rs; id_rt = s.id_rt; id_use_rs = s.id_use_rs;
    id_use_rt = s.id_use_rt; ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_rd = s.ex_rd;
    ex_load = s.ex_load; ex_rf_en = s.ex_rf_en; ex_branch_taken = s.br; mem_rd = s.mem_rd;
    mem_rf_en = s.mem_rf_en; wb_rd = s.wb_rd; wb_rf_en = s.wb_rf_en; mem_busy = s.mem_busy;
    #1;
    cycle++;
    for (int k = 0; k < 2; k++) begin
      int pc, ifd, fl, idx, bub, exm, fa, fb;
      logic [9:0] expv;
      pc = 1; ifd = 1; fl = 0; idx = 1; bub = 0; exm = 1;
      fa = fwdModel(s, s.ex_rs);
      fb = fwdModel(s, s.ex_rt);
      if (s.reset) begin
        pc = 0; ifd = 0; idx = 0; exm = 0; bub = 1; fa = 0; fb = 0;
      end else if (s.mem_busy) begin
        pc = 0; ifd = 0; idx = 0; exm = 0;
      end else if (s.br) begin
        fl = 1; bub = 1;
      end else if (owed[k] > 0 || luModel(s)) begin
        pc = 0; ifd = 0; bub = 1;
      end
      expv = {pc[0], ifd[0], fl[0], idx[0], bub[0], exm[0], fa[1:0], fb[1:0]};
      checkOutput(k == 0 ? "ctl_a" : "ctl_b", 32'(k == 0 ? ctl_a : ctl_b), 32'(expv));
      checkOutput(k == 0 ? "stall_a" : "stall_b", k == 0 ? 32'(sc_a) : 32'(sc_b), 32'(m_stall[k]));
      checkOutput(k == 0 ? "flush_a" : "flush_b", k == 0 ? 32'(fc_a) : 32'(fc_b), 32'(m_flush[k]));
      if (s.reset) begin
        owed[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (pc == 0) m_stall[k] = satInc(m_stall[k], cnt_w[k]);
        if (!s.mem_busy) begin
          if (s.br) begin
            m_flush[k] = satInc(m_flush[k], cnt_w[k]);
            owed[k] = 0;
          end else if (owed[k] > 0) begin
            owed[k]--;
          end else if (luModel(s)) begin
            owed[k] = lu_len[k] - 1;
          end
        end
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 0, id_rs: 0, id_rt: 0, id_use_rs: 0, id_use_rt: 0, ex_rs: 0, ex_rt: 0,
          ex_rd: 0, ex_load: 0, ex_rf_en: 0, br: 0, mem_rd: 0, mem_rf_en: 0, wb_rd: 0,
          wb_rf_en: 0, mem_busy: 0};
    return s;
  endfunction

  function automatic stim_t hazard(input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.ex_load = 1; s.ex_rf_en = 1; s.ex_rd = rd; s.id_use_rs = 1; s.id_rs = rd;
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle(); s.reset = 1;
    repeat (3) applyStimulus(s);
    checkOutput("reset_ctl", 32'(ctl_a), 32'b0000100000);

    applyStimulus(hazard(5'd5));
    applyStimulus(idle());
    checkOutput("lu1_release_b", 32'(ctl_b[9]), 1);
    repeat (3) applyStimulus(idle());
    checkOutput("lu_stall_cnt_a", 32'(sc_a), 3);
    checkOutput("lu_stall_cnt_b", 32'(sc_b), 1);

    applyStimulus(hazard(5'd0));
    applyStimulus(idle());

    applyStimulus(hazard(5'd5));
    s = idle(); s.br = 1;
    applyStimulus(s);
    checkOutput("br_in_stall", 32'({ctl_a[9], ctl_a[7], ctl_a[5]}), 32'b111);
    applyStimulus(idle());
    checkOutput("after_br", 32'({ctl_a[9], ctl_a[5]}), 32'b10);

    s = idle(); s.ex_rs = 7; s.mem_rd = 7; s.mem_rf_en = 1; s.wb_rd = 7; s.wb_rf_en = 1;
    applyStimulus(s);
    checkOutput("fwd_mem", 32'(ctl_a[3:2]), 2);
    s.mem_rf_en = 0;
    applyStimulus(s);
    checkOutput("fwd_wb", 32'(ctl_a[3:2]), 1);
    s.ex_rt = 0; s.mem_rd = 0; s.wb_rd = 0; s.mem_rf_en = 1;
    applyStimulus(s);
    checkOutput("fwd_r0", 32'(ctl_a[1:0]), 0);

    s = hazard(5'd9); s.br = 1; s.mem_busy = 1;
    repeat (4) applyStimulus(s);
    s.mem_busy = 0;
    applyStimulus(s);
    checkOutput("br_after_busy", 32'(ctl_a[7]), 1);
    applyStimulus(idle());

    s = idle(); s.reset = 1;
    applyStimulus(s);
    s = idle(); s.mem_busy = 1;
    repeat (14) applyStimulus(s);
    repeat (2) applyStimulus(hazard(5'd3));
    applyStimulus(idle());
    checkOutput("stall_sat_b", 32'(sc_b), 15);

    applyStimulus(hazard(5'd4));
    s = idle(); s.reset = 1;
    applyStimulus(s);
    applyStimulus(idle());
    checkOutput("pc_after_reset", 32'(ctl_a[9]), 1);

    for (int i = 0; i < 4000; i++) begin
      s.reset     = ($urandom_range(99) == 0);
      s.id_rs     = 5'($urandom_range(3));
      s.id_rt     = 5'($urandom_range(3));
      s.id_use_rs = 1'($urandom);
      s.id_use_rt = 1'($urandom);
      s.ex_rs     = 5'($urandom_range(3));
      s.ex_rt     = 5'($urandom_range(3));
      s.ex_rd     = 5'($urandom_range(3));
      s.ex_load   = 1'($urandom);
      s.ex_rf_en  = ($urandom_range(3) != 0);
      s.br        = ($urandom_range(9) == 0);
      s.mem_rd    = 5'($urandom_range(3));
      s.mem_rf_en = 1'($urandom);
      s.wb_rd     = 5'($urandom_range(3));
      s.wb_rf_en  = 1'($urandom);
      s.mem_busy  = ($urandom_range(6) == 0);
      applyStimulus(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
